// File: rtl/sdram_fsm_if.sv
// Request/status bundle between the SDRAM sequencer and its requester and command encoder.
// master = requester side (drives requests), slave = sequencer side (drives state and strobes).
interface sdram_fsm_if;
  logic        wr_sdram_req;
  logic        rd_sdram_req;
  logic [4:0]  init_st;
  logic [4:0]  work_st;
  logic [15:0] cnt_work;
  logic [2:0]  sys_state;
  logic        init_done;
  logic        wr_data_en;
  logic        rd_data_vld;
  logic        wr_ack;
  logic        rd_ack;

  modport master (
    output wr_sdram_req, rd_sdram_req,
    input  init_st, work_st, cnt_work, sys_state, init_done,
    input  wr_data_en, rd_data_vld, wr_ack, rd_ack
  );

  modport slave (
    input  wr_sdram_req, rd_sdram_req,
    output init_st, work_st, cnt_work, sys_state, init_done,
    output wr_data_en, rd_data_vld, wr_ack, rd_ack
  );
endinterface

// File: rtl/sdram_fsm.sv
// SDRAM sequencer: power-up init, then refresh / read-burst / write-burst arbitration.
// All outputs registered; requests are level-held and only sampled in W_IDLE.
module sdram_fsm #(
  parameter int T200US     = 20000,
  parameter int TRP        = 2,
  parameter int TRFC       = 7,
  parameter int TMRD       = 2,
  parameter int TRCD       = 2,
  parameter int CL         = 3,
  parameter int BURST_LEN  = 512,
  parameter int REF_PERIOD = 1560
) (
  input logic       clk,
  input logic       rst_n,
  sdram_fsm_if.slave bus
);

  typedef enum logic [4:0] {
    I_200US, I_PRE, I_WAIT_PRE,
    I_REF1, I_REF2, I_REF3, I_REF4, I_REF5, I_REF6, I_REF7, I_REF8,
    I_WAIT_RE1, I_WAIT_RE2, I_WAIT_RE3, I_WAIT_RE4,
    I_WAIT_RE5, I_WAIT_RE6, I_WAIT_RE7, I_WAIT_RE8,
    I_MRS, I_WATI_MRS, I_DONE
  } init_st_t;

  typedef enum logic [4:0] {
    W_IDLE, W_ACTIVE, W_TRCD, W_REF, W_RC, W_READ, W_RDDAT, W_CL,
    W_WRITE, W_PRECH, W_TRP, W_BSTOP, W_CHGACT, W_TRPACT
  } work_st_t;

  localparam logic [2:0] SYS_IDLE  = 3'd0;
  localparam logic [2:0] SYS_READ  = 3'd1;
  localparam logic [2:0] SYS_WRITE = 3'd2;
  localparam logic [2:0] SYS_REF   = 3'd3;
  localparam logic [2:0] SYS_INIT  = 3'd4;

  init_st_t    init_st;
  work_st_t    work_st;
  logic [15:0] cnt_work;
  logic [15:0] ref_timer;
  logic [15:0] init_len;
  logic [15:0] work_len;
  logic [2:0]  sys_state;
  logic        init_done;
  logic        wr_data_en;
  logic        rd_data_vld;
  logic        wr_ack;
  logic        rd_ack;
  logic        ref_pend;
  logic        init_last;
  logic        work_last;
  logic        ref_wrap;

  always_comb begin
    init_len = 16'd1;
    case (init_st)
      I_200US:    init_len = 16'(T200US);
      I_WAIT_PRE: init_len = 16'(TRP);
      I_WAIT_RE1, I_WAIT_RE2, I_WAIT_RE3, I_WAIT_RE4,
      I_WAIT_RE5, I_WAIT_RE6, I_WAIT_RE7, I_WAIT_RE8:
                  init_len = 16'(TRFC);
      I_WATI_MRS: init_len = 16'(TMRD);
      default:    ;
    endcase
    work_len = 16'd1;
    case (work_st)
      W_TRCD:           work_len = 16'(TRCD);
      W_RC:             work_len = 16'(TRFC);
      W_CL:             work_len = 16'(CL);
      W_RDDAT, W_WRITE: work_len = 16'(BURST_LEN);
      W_TRP:            work_len = 16'(TRP);
      default:          ;
    endcase
  end

  assign init_last = (cnt_work == init_len - 16'd1);
  assign work_last = (cnt_work == work_len - 16'd1);
  assign ref_wrap  = (ref_timer == 16'(REF_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_st     <= I_200US;
      work_st     <= W_IDLE;
      cnt_work    <= '0;
      sys_state   <= SYS_INIT;
      init_done   <= 1'b0;
      wr_data_en  <= 1'b0;
      rd_data_vld <= 1'b0;
      wr_ack      <= 1'b0;
      rd_ack      <= 1'b0;
      ref_timer   <= '0;
      ref_pend    <= 1'b0;
    end else begin
      rd_ack <= 1'b0;
      wr_ack <= 1'b0;
      if (cnt_work != 16'hFFFF)
        cnt_work <= cnt_work + 16'd1;
      // A wrap that lands while a refresh is already pending is absorbed, not queued.
      if (init_done) begin
        ref_timer <= ref_wrap ? '0 : ref_timer + 16'd1;
        if (ref_wrap)
          ref_pend <= 1'b1;
      end

      if (init_st != I_DONE) begin
        if (init_last) begin
          cnt_work <= '0;
          case (init_st)
            I_REF1, I_REF2, I_REF3, I_REF4, I_REF5, I_REF6, I_REF7, I_REF8:
              init_st <= init_st_t'(init_st + 5'd8);
            I_WAIT_RE1, I_WAIT_RE2, I_WAIT_RE3, I_WAIT_RE4,
            I_WAIT_RE5, I_WAIT_RE6, I_WAIT_RE7:
              init_st <= init_st_t'(init_st - 5'd7);
            I_WATI_MRS: begin
              init_st   <= I_DONE;
              init_done <= 1'b1;
              sys_state <= SYS_IDLE;
            end
            default:
              init_st <= init_st_t'(init_st + 5'd1);
          endcase
        end
      end else if (work_st == W_IDLE) begin
        if (ref_pend) begin
          work_st   <= W_REF;
          sys_state <= SYS_REF;
          ref_pend  <= 1'b0;
          cnt_work  <= '0;
        end else if (bus.rd_sdram_req) begin
          work_st   <= W_ACTIVE;
          sys_state <= SYS_READ;
          cnt_work  <= '0;
        end else if (bus.wr_sdram_req) begin
          work_st   <= W_ACTIVE;
          sys_state <= SYS_WRITE;
          cnt_work  <= '0;
        end
      end else if (work_last) begin
        cnt_work <= '0;
        case (work_st)
          W_REF:    work_st <= W_RC;
          W_ACTIVE: work_st <= W_TRCD;
          W_TRCD: begin
            // sys_state doubles as the remembered transaction type.
            if (sys_state == SYS_READ) begin
              work_st <= W_READ;
            end else begin
              work_st    <= W_WRITE;
              wr_data_en <= 1'b1;
            end
          end
          W_READ:   work_st <= W_CL;
          W_CL: begin
            work_st     <= W_RDDAT;
            rd_data_vld <= 1'b1;
          end
          W_RDDAT: begin
            work_st     <= W_PRECH;
            rd_data_vld <= 1'b0;
          end
          W_WRITE: begin
            work_st    <= W_BSTOP;
            wr_data_en <= 1'b0;
          end
          W_BSTOP:  work_st <= W_PRECH;
          W_PRECH:  work_st <= W_TRP;
          W_TRP: begin
            work_st   <= W_IDLE;
            rd_ack    <= (sys_state == SYS_READ);
            wr_ack    <= (sys_state == SYS_WRITE);
            sys_state <= SYS_IDLE;
          end
          default: begin
            work_st   <= W_IDLE;
            sys_state <= SYS_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.init_st     = init_st;
  assign bus.work_st     = work_st;
  assign bus.cnt_work    = cnt_work;
  assign bus.sys_state   = sys_state;
  assign bus.init_done   = init_done;
  assign bus.wr_data_en  = wr_data_en;
  assign bus.rd_data_vld = rd_data_vld;
  assign bus.wr_ack      = wr_ack;
  assign bus.rd_ack      = rd_ack;

endmodule

// File: tb/tb_sdram_fsm.sv
// Bench for sdram_fsm: cycle-exact vector table for init + read/write bursts, plus
// directed sequences for refresh arbitration and asynchronous reset mid-burst.
module tb_sdram_fsm;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdram_fsm_if a_if ();
  sdram_fsm_if b_if ();

  sdram_fsm #(.T200US(20), .TRP(2), .TRFC(7), .TMRD(2), .TRCD(2), .CL(3),
              .BURST_LEN(512), .REF_PERIOD(1560))
    dut_a (.clk(clk), .rst_n(rst_a_n), .bus(a_if.slave));

  sdram_fsm #(.T200US(20), .TRP(2), .TRFC(7), .TMRD(2), .TRCD(2), .CL(3),
              .BURST_LEN(512), .REF_PERIOD(100))
    dut_b (.clk(clk), .rst_n(rst_b_n), .bus(b_if.slave));

  typedef struct {
    int rd, wr;          // request levels driven after this cycle's check
    int ist, wst, sys;   // expected init_st, work_st, sys_state
    int len, cnt0;       // cycles in this row, cnt_work at the first one
    int idone, wen, rvld, wack, rack;
  } vec_t;

  vec_t tbl[$];

  localparam logic [33:0] RESET_VEC = {5'd0, 5'd0, 3'd4, 16'd0, 5'b0};

  function automatic logic [33:0] obs_a();
    return {a_if.init_st, a_if.work_st, a_if.sys_state, a_if.cnt_work, a_if.init_done,
            a_if.wr_data_en, a_if.rd_data_vld, a_if.wr_ack, a_if.rd_ack};
  endfunction

  function automatic logic [33:0] obs_b();
    return {b_if.init_st, b_if.work_st, b_if.sys_state, b_if.cnt_work, b_if.init_done,
            b_if.wr_data_en, b_if.rd_data_vld, b_if.wr_ack, b_if.rd_ack};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input int rd, input int wr, input int ist, input int wst, input int sys,
                     input int len, input int cnt0, input int idone, input int wen,
                     input int rvld, input int wack, input int rack);
    vec_t v;
    v = '{rd, wr, ist, wst, sys, len, cnt0, idone, wen, rvld, wack, rack};
    tbl.push_back(v);
  endtask

  task automatic run_rows(input int first, input int last, input bit drive);
    for (int r = first; r <= last; r++) begin
      for (int i = 0; i < tbl[r].len; i++) begin
        check($sformatf("row%0d_cyc%0d", r, i), 64'(obs_a()),
              64'({5'(tbl[r].ist), 5'(tbl[r].wst), 3'(tbl[r].sys), 16'(tbl[r].cnt0 + i),
                   1'(tbl[r].idone), 1'(tbl[r].wen), 1'(tbl[r].rvld),
                   1'(tbl[r].wack), 1'(tbl[r].rack)}));
        if (drive) begin
          a_if.rd_sdram_req = 1'(tbl[r].rd);
          a_if.wr_sdram_req = 1'(tbl[r].wr);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, tb, init_end, last_row, wen_cnt, ref_cnt;
    a_if.rd_sdram_req = 1'b0;
    a_if.wr_sdram_req = 1'b0;
    b_if.rd_sdram_req = 1'b0;
    b_if.wr_sdram_req = 1'b0;

    // Init: requests raised during I_wati_mrs must not start work before I_done.
    add(0, 0, 0, 0, 4, 20, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 2, 0, 4, 2, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      add(0, 0, 2 + k, 0, 4, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 10 + k, 0, 4, 7, 0, 0, 0, 0, 0, 0);
    end
    add(0, 0, 19, 0, 4, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 20, 0, 4, 2, 0, 0, 0, 0, 0, 0);
    init_end = tbl.size();
    add(1, 1, 21, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    // Simultaneous rd+wr: read first.
    add(1, 1, 21, 1, 1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 21, 2, 1, 2, 0, 1, 0, 0, 0, 0);
    add(1, 1, 21, 5, 1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 21, 7, 1, 3, 0, 1, 0, 0, 0, 0);
    add(1, 1, 21, 6, 1, 512, 0, 1, 0, 1, 0, 0);
    add(1, 1, 21, 9, 1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 21, 10, 1, 2, 0, 1, 0, 0, 0, 0);
    add(0, 1, 21, 0, 0, 1, 0, 1, 0, 0, 0, 1);
    // Write served straight after the read's ack cycle.
    add(0, 1, 21, 1, 2, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 21, 2, 2, 2, 0, 1, 0, 0, 0, 0);
    add(0, 1, 21, 8, 2, 512, 0, 1, 1, 0, 0, 0);
    add(0, 1, 21, 11, 2, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 21, 9, 2, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 21, 10, 2, 2, 0, 1, 0, 0, 0, 0);
    add(0, 0, 21, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    add(0, 0, 21, 0, 0, 10, 1, 1, 0, 0, 0, 0);
    last_row = tbl.size() - 1;

    repeat (3) @(negedge clk);
    check("reset_a", 64'(obs_a()), 64'(RESET_VEC));
    check("reset_b", 64'(obs_b()), 64'(RESET_VEC));

    rst_a_n = 1'b1;
    t0 = cyc;
    run_rows(0, init_end - 1, 1'b1);
    check("init_done_cycle", 64'(cyc - t0), 64'(90));
    run_rows(init_end, last_row, 1'b1);

    // First periodic refresh: wrap 1560 cycles after I_done, W_REF one cycle later.
    for (int i = 0; i < 1000 && a_if.work_st != 5'd3; i++) @(negedge clk);
    check("ref_a_cycle", 64'(cyc - t0), 64'(1651));
    check("ref_a_state", 64'({a_if.work_st, a_if.sys_state}), 64'({5'd3, 3'd3}));
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("ref_a_rc%0d", i), 64'(obs_a()),
            64'({5'd21, 5'd4, 3'd3, 16'(i), 5'b10000}));
    end
    @(negedge clk);
    check("ref_a_idle", 64'(obs_a()), 64'({5'd21, 5'd0, 3'd0, 16'd0, 5'b10000}));

    // Asynchronous reset in the middle of a read burst.
    a_if.rd_sdram_req = 1'b1;
    for (int i = 0; i < 400 && !(a_if.work_st == 5'd6 && a_if.cnt_work == 16'd200); i++)
      @(negedge clk);
    check("rddat_200", 64'({a_if.work_st, a_if.cnt_work, a_if.rd_data_vld, a_if.sys_state}),
          64'({5'd6, 16'd200, 1'b1, 3'd1}));
    rst_a_n = 1'b0;
    a_if.rd_sdram_req = 1'b0;
    #1;
    check("async_reset", 64'(obs_a()), 64'(RESET_VEC));
    @(negedge clk);
    @(negedge clk);
    check("reset_hold", 64'(obs_a()), 64'(RESET_VEC));
    rst_a_n = 1'b1;
    run_rows(0, init_end, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("post_reset_idle%0d", i), 64'(obs_a()),
            64'({5'd21, 5'd0, 3'd0, 16'(i + 1), 5'b10000}));
      @(negedge clk);
    end

    // Refresh arbitration with REF_PERIOD=100 on the second instance.
    rst_b_n = 1'b1;
    tb = cyc;
    for (int i = 0; i < 200 && !b_if.init_done; i++) @(negedge clk);
    check("init_b_cycle", 64'(cyc - tb), 64'(90));
    b_if.wr_sdram_req = 1'b1;
    wen_cnt = 0;
    ref_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      wen_cnt += int'(b_if.wr_data_en);
      ref_cnt += int'(b_if.work_st == 5'd3);
      if (b_if.wr_ack) break;
    end
    check("wr_ack_b", 64'(b_if.wr_ack), 64'(1));
    check("wr_ack_b_cycle", 64'(cyc - tb), 64'(610));
    check("wr_en_count", 64'(wen_cnt), 64'(512));
    check("no_ref_in_write", 64'(ref_cnt), 64'(0));
    b_if.wr_sdram_req = 1'b0;
    @(negedge clk);
    check("ref_b1", 64'(obs_b()), 64'({5'd21, 5'd3, 3'd3, 16'd0, 5'b10000}));
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("ref_b_rc%0d", i), 64'(obs_b()),
            64'({5'd21, 5'd4, 3'd3, 16'(i), 5'b10000}));
    end
    @(negedge clk);
    check("ref_b_idle", 64'({b_if.work_st, b_if.sys_state}), 64'(0));

    // ref_pend cleared: next refresh only after the wrap at cycle 690.
    ref_cnt = 0;
    for (int i = 0; i < 200 && (cyc - tb) < 690; i++) begin
      @(negedge clk);
      ref_cnt += int'(b_if.work_st == 5'd3);
    end
    check("no_early_ref", 64'(ref_cnt), 64'(0));
    b_if.rd_sdram_req = 1'b1;
    @(negedge clk);
    check("ref_b2_cycle", 64'(cyc - tb), 64'(691));
    check("ref_over_rd", 64'({b_if.work_st, b_if.sys_state}), 64'({5'd3, 3'd3}));
    repeat (9) @(negedge clk);
    check("rd_after_ref", 64'({b_if.work_st, b_if.sys_state, b_if.cnt_work}),
          64'({5'd1, 3'd1, 16'd0}));
    ref_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ref_cnt += int'(b_if.work_st == 5'd3);
      if (b_if.rd_ack) break;
    end
    check("rd_ack_b_cycle", 64'(cyc - tb), 64'(1222));
    check("no_ref_in_read", 64'(ref_cnt), 64'(0));
    b_if.rd_sdram_req = 1'b0;
    @(negedge clk);
    check("ref_after_read", 64'({b_if.work_st, b_if.sys_state, b_if.rd_ack}),
          64'({5'd3, 3'd3, 1'b0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
